divider_8_bit: RTL and testbench



---
 rtl/divider_8_bit_pkg.sv | 11 +
 rtl/divider_8_bit_if.sv | 28 ++
 rtl/divider_8_bit_div_step.sv | 24 ++
 rtl/divider_8_bit.sv | 117 +++++++++++
 tb/tb_divider_8_bit.sv | 134 +++++++++++++
 5 files changed

// File: rtl/divider_8_bit_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Used by the divider top, its step datapath, and the handshake interface.
package divider_pkg;
    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;
endpackage

// File: rtl/divider_8_bit_if.sv
// Start/busy/done handshake and operand/result bundle for divider_8_bit.
// The master drives the request; the slave (the divider) returns results and status.
interface divider_8_bit_if
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             ovfl;

    modport master (
        output start, mode, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, ovfl
    );

    modport slave (
        input  start, mode, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, ovfl
    );
endinterface

// File: rtl/divider_8_bit_div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor.
// Purely combinational; the partial remainder is always below the divisor, so WIDTH bits hold it.
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    // Trial sign is decided at WIDTH+1 bits; once it fits, the low bits alone carry the difference.
    assign w_fits  = (w_shift >= {1'b0, i_dvs});
    assign w_diff  = w_shift[WIDTH-1:0] - i_dvs;
    assign o_rem   = w_fits ? w_diff : w_shift[WIDTH-1:0];
    assign o_quo   = {i_quo[WIDTH-2:0], w_fits};
endmodule

// File: rtl/divider_8_bit.sv
// Sequential restoring divider, unsigned or signed per op; done after WIDTH+1 edges (1 edge on divide-by-zero).
// start is ignored while busy or during the done cycle; DIVIDER_EARLY_DONE_EN skips CALC when |divisor| > |dividend|.
module divider_8_bit
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    divider_8_bit_if.slave  bus
);
    localparam int               CW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       r_state, w_state_nxt;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_dividend;
    logic             r_sign_q, r_sign_r, r_dbz, r_ovfl_pend;
    logic [WIDTH-1:0] r_quotient, r_remainder;
    logic             r_busy, r_done, r_div_by_zero, r_ovfl;

    logic             w_accept, w_dvs_zero, w_early;
    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_rem_nxt, w_quo_nxt;

    assign w_accept   = (r_state == IDLE) & bus.start & ~r_done;
    assign w_dvs_zero = (bus.divisor == '0);
    // -MIN_NEG wraps back to MIN_NEG, which read unsigned is exactly its magnitude.
    assign w_dvd_mag  = (bus.mode & bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign w_dvs_mag  = (bus.mode & bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

`ifdef DIVIDER_EARLY_DONE_EN
    assign w_early = ~w_dvs_zero & (w_dvs_mag > w_dvd_mag);
`else
    assign w_early = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_dvs_zero | w_early) ? FIX : CALC;
            CALC:    if (r_count == '0) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count       <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_dividend    <= '0;
            r_sign_q      <= 1'b0;
            r_sign_r      <= 1'b0;
            r_dbz         <= 1'b0;
            r_ovfl_pend   <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_ovfl        <= 1'b0;
        end else begin
            r_done <= (r_state == FIX);
            if (w_accept) begin
                r_dividend  <= bus.dividend;
                r_dbz       <= w_dvs_zero;
                r_dvs       <= w_dvs_mag;
                r_quo       <= w_early ? '0 : w_dvd_mag;
                r_rem       <= w_early ? w_dvd_mag : '0;
                r_sign_q    <= bus.mode & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                r_sign_r    <= bus.mode & bus.dividend[WIDTH-1];
                r_ovfl_pend <= bus.mode & (bus.dividend == MIN_NEG) & (bus.divisor == '1);
                r_count     <= CW'(WIDTH - 1);
                r_busy      <= 1'b1;
            end else if (r_state == CALC) begin
                r_rem   <= w_rem_nxt;
                r_quo   <= w_quo_nxt;
                r_count <= r_count - 1'b1;
            end else if (r_state == FIX) begin
                r_busy <= 1'b0;
                if (r_dbz) begin
                    r_quotient    <= '1;
                    r_remainder   <= r_dividend;
                    r_div_by_zero <= 1'b1;
                    r_ovfl        <= 1'b0;
                end else begin
                    r_quotient    <= r_sign_q ? -r_quo : r_quo;
                    r_remainder   <= r_sign_r ? -r_rem : r_rem;
                    r_div_by_zero <= 1'b0;
                    r_ovfl        <= r_ovfl_pend;
                end
            end
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.ovfl        = r_ovfl;
endmodule

// File: tb/tb_divider_8_bit.sv
// Directed-vector bench for divider_8_bit: hand-computed results, latency, flags, handshake and reset abort.
module tb_divider_8_bit;
    import divider_pkg::*;

`ifdef DIVIDER_EARLY_DONE_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 9;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    divider_8_bit_if #(.WIDTH(8)) bus ();

    divider_8_bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, " quotient"},  32'(bus.quotient),    32'h0);
        chk({tag, " remainder"}, 32'(bus.remainder),   32'h0);
        chk({tag, " busy"},      32'(bus.busy),        32'h0);
        chk({tag, " done"},      32'(bus.done),        32'h0);
        chk({tag, " dbz"},       32'(bus.div_by_zero), 32'h0);
        chk({tag, " ovfl"},      32'(bus.ovfl),        32'h0);
    endtask

    // poke_at > 0 re-pulses start with other operands after that edge to prove it is ignored.
    task automatic run_op(input string tag, input logic m, input logic [7:0] a, input logic [7:0] b,
                          input int lat_exp, input logic [7:0] q_exp, input logic [7:0] r_exp,
                          input logic dbz_exp, input logic ov_exp, input int poke_at);
        int lat = -1;
        repeat (2) @(negedge clk);
        bus.mode     = m;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) chk({tag, " busy"}, 32'(bus.busy), 32'(lat_exp > 1));
            if (k == poke_at) begin
                bus.start    = 1'b1;
                bus.mode     = 1'b0;
                bus.dividend = 8'd200;
                bus.divisor  = 8'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.start = 1'b0;
        chk({tag, " latency"},   32'(lat),             32'(lat_exp));
        chk({tag, " quotient"},  32'(bus.quotient),    32'(q_exp));
        chk({tag, " remainder"}, 32'(bus.remainder),   32'(r_exp));
        chk({tag, " dbz"},       32'(bus.div_by_zero), 32'(dbz_exp));
        chk({tag, " ovfl"},      32'(bus.ovfl),        32'(ov_exp));
        chk({tag, " busy_end"},  32'(bus.busy),        32'h0);
    endtask

    initial begin
        int n_done;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;

        run_op("u100/7",   1'b0, 8'd100, 8'd7,  9, 8'd14,  8'd2,  1'b0, 1'b0, 0);
        run_op("poke",     1'b0, 8'd100, 8'd7,  9, 8'd14,  8'd2,  1'b0, 1'b0, 3);
        run_op("u200/3",   1'b0, 8'd200, 8'd3,  9, 8'd66,  8'd2,  1'b0, 1'b0, 0);
        run_op("u255/1",   1'b0, 8'd255, 8'd1,  9, 8'd255, 8'd0,  1'b0, 1'b0, 0);
        run_op("s-100/7",  1'b1, 8'h9C,  8'd7,  9, 8'hF2,  8'hFE, 1'b0, 1'b0, 0);
        run_op("s100/-7",  1'b1, 8'd100, 8'hF9, 9, 8'hF2,  8'h02, 1'b0, 1'b0, 0);
        run_op("s-7/-2",   1'b1, 8'hF9,  8'hFE, 9, 8'h03,  8'hFF, 1'b0, 1'b0, 0);
        run_op("s-128/1",  1'b1, 8'h80,  8'h01, 9, 8'h80,  8'h00, 1'b0, 1'b0, 0);
        run_op("ovfl",     1'b1, 8'h80,  8'hFF, 9, 8'h80,  8'h00, 1'b0, 1'b1, 0);
        run_op("u5/9",     1'b0, 8'd5,   8'd9,  EARLY_LAT, 8'd0, 8'd5,  1'b0, 1'b0, 0);
        run_op("s-3/7",    1'b1, 8'hFD,  8'd7,  EARLY_LAT, 8'd0, 8'hFD, 1'b0, 1'b0, 0);
        run_op("s-128/0",  1'b1, 8'h80,  8'h00, 1, 8'hFF,  8'h80, 1'b1, 1'b0, 0);
        run_op("u55/0",    1'b0, 8'd55,  8'd0,  1, 8'hFF,  8'h37, 1'b1, 1'b0, 0);

        // Abort an operation mid-flight: outputs clear at once and no done follows.
        repeat (2) @(negedge clk);
        bus.mode     = 1'b0;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd3;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_idle_zero("abort");
        n_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        chk("abort no_done", 32'(n_done), 32'h0);

        run_op("post_rst", 1'b0, 8'd200, 8'd3,  9, 8'd66,  8'd2,  1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
